// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request, drives the ALU, returns result.
// Optional completed-op counter enabled by defining ALU_OP_COUNT_EN.
module alu_issue_ctrl #(
  parameter int DATAPATH_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                req_func,
  input  logic [DATAPATH_WIDTH-1:0] req_a,
  input  logic [DATAPATH_WIDTH-1:0] req_b,
  input  logic [4:0]                req_tag,
  output logic [DATAPATH_WIDTH-1:0] alu_a,
  output logic [DATAPATH_WIDTH-1:0] alu_b,
  output logic [3:0]                alu_ctrl,
  input  logic [DATAPATH_WIDTH-1:0] alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATAPATH_WIDTH-1:0] rsp_data,
  output logic [4:0]                rsp_tag,
  output logic                      rsp_taken,
  output logic                      rsp_illegal,
  output logic [31:0]               op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATAPATH_WIDTH-1:0] r_alu_a;
  logic [DATAPATH_WIDTH-1:0] r_alu_b;
  logic [3:0]                r_alu_ctrl;
  logic [4:0]                r_tag;
  logic                      r_illegal;
  logic                      r_is_beq;
  logic                      r_is_bne;
  logic                      r_rsp_valid;
  logic [DATAPATH_WIDTH-1:0] r_rsp_data;
  logic [4:0]                r_rsp_tag;
  logic                      r_rsp_taken;
  logic                      r_rsp_illegal;

  logic [3:0] w_ctrl;
  logic       w_illegal;
  logic       w_accept;
  logic       w_rsp_hs;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_rsp_hs = r_rsp_valid && rsp_ready;

  // Translate instruction function code into ALU control encoding
  always_comb begin
    w_ctrl    = 4'd0;
    w_illegal = 1'b0;
    unique case (req_func)
      4'h0:    w_ctrl = 4'd1;
      4'h1:    w_ctrl = 4'd2;
      4'h2:    w_ctrl = 4'd3;
      4'h3:    w_ctrl = 4'd4;
      4'h4:    w_ctrl = 4'd5;
      4'h5:    w_ctrl = 4'd6;
      4'h6:    w_ctrl = 4'd7;
      4'h7:    w_ctrl = 4'd8;
      4'h8:    w_ctrl = 4'd9;
      4'h9:    w_ctrl = 4'd2;
      4'hA:    w_ctrl = 4'd2;
      default: w_illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture on accept; held between operations
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_ctrl <= '0;
      r_tag      <= '0;
      r_illegal  <= 1'b0;
      r_is_beq   <= 1'b0;
      r_is_bne   <= 1'b0;
    end else if (w_accept) begin
      r_alu_a    <= req_a;
      r_alu_b    <= req_b;
      r_alu_ctrl <= w_ctrl;
      r_tag      <= req_tag;
      r_illegal  <= w_illegal;
      r_is_beq   <= (req_func == 4'h9);
      r_is_bne   <= (req_func == 4'hA);
    end
  end

  // Response capture at end of EXEC, release on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
      r_rsp_taken   <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_data    <= alu_result;
      r_rsp_tag     <= r_tag;
      r_rsp_illegal <= r_illegal;
      r_rsp_taken   <= (r_is_beq && alu_zero) ||
                       (r_is_bne && !alu_zero);
    end else if (r_state == RESP && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_OP_COUNT_EN
  logic [31:0] r_op_count;

  // Count completed response handshakes, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_op_count <= '0;
    else if (w_rsp_hs) r_op_count <= r_op_count + 32'd1;
  end

  assign op_count = r_op_count;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
  assign op_count    = 32'd0;
`endif

  assign req_ready   = (r_state == IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctrl    = r_alu_ctrl;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_taken   = r_rsp_taken;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl with a stand-in ALU and
// a function-level reference model.
module tb_alu_issue_ctrl;

  localparam int W = 64;
  localparam logic [W-1:0] DEAF = 64'hdeafdeafdeafdeaf;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_func;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [4:0]   req_tag;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [4:0]   rsp_tag;
  logic         rsp_taken;
  logic         rsp_illegal;
  logic [31:0]  op_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATAPATH_WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a),
    .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal),
    .op_count(op_count)
  );

  // Stand-in for the alu block, keyed by control code
  always_comb begin
    alu_result = DEAF;
    case (alu_ctrl)
      4'd1: alu_result = alu_a + alu_b;
      4'd2: alu_result = alu_a - alu_b;
      4'd3: alu_result = alu_a & alu_b;
      4'd4: alu_result = alu_a | alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: alu_result = alu_a ^ alu_b;
      4'd7: alu_result = {63'd0, alu_a < alu_b};
      4'd8: alu_result = alu_a << alu_b[5:0];
      4'd9: alu_result = alu_a >> alu_b[5:0];
      default: alu_result = DEAF;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_ctrl(input logic [3:0] f);
    logic [3:0] t [0:10];
    t = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
          4'd7, 4'd8, 4'd9, 4'd2, 4'd2};
    return (f <= 4'hA) ? t[f] : 4'd0;
  endfunction

  function automatic logic [W-1:0] m_data(input logic [3:0] f,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (f)
      4'h0: return a + b;
      4'h1, 4'h9, 4'hA: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return ~a;
      4'h5: return a ^ b;
      4'h6: return (a < b) ? 64'd1 : 64'd0;
      4'h7: return a << b[5:0];
      4'h8: return a >> b[5:0];
      default: return DEAF;
    endcase
  endfunction

  function automatic logic m_taken(input logic [3:0] f,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    if (f == 4'h9) return a == b;
    if (f == 4'hA) return a != b;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_cnt();
`ifdef ALU_OP_COUNT_EN
    return W'(exp_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic do_op(input logic [3:0] f,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [4:0] tg,
                       input int stall);
    logic [W-1:0] ed;
    ed = m_data(f, a, b);
    chk("ready_idle", W'(req_ready), 1);
    req_valid = 1'b1;
    req_func  = f;
    req_a     = a;
    req_b     = b;
    req_tag   = tg;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_func  = 4'($urandom);
    chk("exec_valid", W'(rsp_valid), 0);
    chk("exec_ready", W'(req_ready), 0);
    chk("alu_ctrl", W'(alu_ctrl), W'(m_ctrl(f)));
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(posedge clk); #1;
    for (int i = 0; i <= stall; i++) begin
      chk("rsp_valid", W'(rsp_valid), 1);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_tag", W'(rsp_tag), W'(tg));
      chk("rsp_taken", W'(rsp_taken), W'(m_taken(f, a, b)));
      chk("rsp_illegal", W'(rsp_illegal), W'(f > 4'hA));
      chk("resp_ready", W'(req_ready), 0);
      if (i < stall) begin
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt++;
    chk("post_valid", W'(rsp_valid), 0);
    chk("post_ready", W'(req_ready), 1);
    chk("alu_hold", alu_b, b);
    chk("op_count", W'(op_count), m_cnt());
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", W'(req_ready), 1);
    chk("rst_valid", W'(rsp_valid), 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_tag", W'(rsp_tag), 0);
    chk("rst_taken", W'(rsp_taken), 0);
    chk("rst_illegal", W'(rsp_illegal), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ctrl", W'(alu_ctrl), 0);
    chk("rst_cnt", W'(op_count), 0);
  endtask

  initial begin
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_func  = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    #12;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(4'h0, 64'd5, 64'd7, 5'd3, 0);
    do_op(4'h9, 64'h55, 64'h55, 5'd4, 0);
    do_op(4'hA, 64'h55, 64'h55, 5'd5, 0);
    do_op(4'hA, 64'd1, 64'd2, 5'd6, 0);
    do_op(4'h7, 64'd1, 64'h43, 5'd7, 5);
    do_op(4'hC, 64'd9, 64'd9, 5'd8, 1);
    do_op(4'h6, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 0);
    do_op(4'h8, 64'h8000_0000_0000_0000, 64'd63, 5'd10, 0);

    for (int n = 0; n < 40; n++) begin
      f = 4'($urandom);
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      do_op(f, a, b, 5'($urandom), $urandom_range(0, 3));
    end

    req_valid = 1'b1;
    req_func  = 4'h0;
    req_a     = 64'd1;
    req_b     = 64'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", W'(rsp_valid), 1);
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", W'(req_ready), 1);
    chk("rel_valid", W'(rsp_valid), 0);
    do_op(4'h1, 64'd10, 64'd4, 5'd31, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
